// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: 8-digit multiplexed seven-segment scan controller with frame-synchronous shadow load.
// Optional feature: define LZ_BLANK_EN to suppress leading zeros (digit 0 is always shown).
// Output registers follow the scan state by one cycle, so a slot's first lit cycle is the edge after BLANK ends.
module seg_scan_ctrl #(
    parameter int unsigned SCAN_DIV     = 1000,
    parameter int unsigned BLANK_CYCLES = 50
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [31:0] digits_in,
    input  logic [7:0]  dp_in,
    input  logic        load,
    output logic        load_ack,
    output logic [7:0]  seg_out,
    output logic [7:0]  digit_sel,
    output logic [2:0]  slot,
    output logic        frame_done
);
    localparam logic [15:0] SHOW_LD  = 16'(SCAN_DIV - 1);
    localparam logic [15:0] BLANK_LD = 16'(BLANK_CYCLES - 1);
    localparam bit          NO_BLANK = (BLANK_CYCLES == 0);

    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

    state_t      state, state_nxt;
    logic [15:0] cnt, cnt_nxt;
    logic [2:0]  slot_nxt;
    logic [31:0] shadow, stage;
    logic [7:0]  dp_sh, dp_stage;
    logic [7:0]  lz, seg_nxt, sel_nxt;
    logic        pending, wrap, apply, lit;

    function automatic logic [6:0] dec(input logic [3:0] d);
        case (d)
            4'd0:    dec = 7'h3F;
            4'd1:    dec = 7'h06;
            4'd2:    dec = 7'h5B;
            4'd3:    dec = 7'h4F;
            4'd4:    dec = 7'h66;
            4'd5:    dec = 7'h6D;
            4'd6:    dec = 7'h7D;
            4'd7:    dec = 7'h07;
            4'd8:    dec = 7'h7F;
            4'd9:    dec = 7'h6F;
            default: dec = 7'h00;
        endcase
    endfunction

    assign wrap  = en && state == SHOW && cnt == 16'd0 && slot == 3'd7;
    assign apply = (pending || load) && (wrap || state == IDLE);

`ifdef LZ_BLANK_EN
    // lz[i] marks digit i and every digit above it as zero; digit 0 never blanks
    always_comb begin
        lz    = '0;
        lz[7] = shadow[31:28] == 4'd0;
        for (int i = 6; i >= 1; i--) lz[i] = lz[i+1] && (shadow[4*i +: 4] == 4'd0);
    end
`else
    assign lz = '0;
`endif

    // scan state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            slot  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            slot  <= slot_nxt;
        end
    end

    // next scan state: BLANK/SHOW countdown, slot advance, en=0 collapses to IDLE
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        slot_nxt  = slot;
        if (!en) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            slot_nxt  = '0;
        end else if (state == IDLE) begin
            state_nxt = NO_BLANK ? SHOW : BLANK;
            cnt_nxt   = NO_BLANK ? SHOW_LD : BLANK_LD;
        end else if (cnt != 16'd0) begin
            cnt_nxt = cnt - 16'd1;
        end else if (state == BLANK) begin
            state_nxt = SHOW;
            cnt_nxt   = SHOW_LD;
        end else begin
            slot_nxt  = slot + 3'd1;
            state_nxt = NO_BLANK ? SHOW : BLANK;
            cnt_nxt   = NO_BLANK ? SHOW_LD : BLANK_LD;
        end
    end

    // display drive for the current slot; dark outside SHOW or when en drops
    always_comb begin
        lit     = en && state == SHOW;
        sel_nxt = lit ? ~(8'h01 << slot) : 8'hFF;
        seg_nxt = lit ? {dp_sh[slot], lz[slot] ? 7'h00 : dec(shadow[{slot, 2'b00} +: 4])} : 8'h00;
    end

    // registered outputs, pulses and the frame-synchronous shadow load
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_out    <= 8'h00;
            digit_sel  <= 8'hFF;
            load_ack   <= 1'b0;
            frame_done <= 1'b0;
            pending    <= 1'b0;
            shadow     <= '0;
            dp_sh      <= '0;
            stage      <= '0;
            dp_stage   <= '0;
        end else begin
            seg_out    <= seg_nxt;
            digit_sel  <= sel_nxt;
            load_ack   <= apply;
            frame_done <= wrap;
            pending    <= (pending || load) && !apply;
            if (load) begin
                stage    <= digits_in;
                dp_stage <= dp_in;
            end
            if (apply) begin
                shadow <= load ? digits_in : stage;
                dp_sh  <= load ? dp_in : dp_stage;
            end
        end
    end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed bench for seg_scan_ctrl with SCAN_DIV=4, BLANK_CYCLES=2.
module tb_seg_scan_ctrl;
`ifdef LZ_BLANK_EN
    localparam logic [7:0] Z = 8'h00;
`else
    localparam logic [7:0] Z = 8'h3F;
`endif

    logic        clk = 1'b0;
    logic        rst, en, load, load_ack, frame_done;
    logic [31:0] digits_in;
    logic [7:0]  dp_in, seg_out, digit_sel;
    logic [2:0]  slot;
    int          vec = 0;
    int          err = 0;
    logic [7:0]  f1 [8] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07};
    logic [7:0]  f4 [8] = '{8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F};
    logic [7:0]  f7 [8] = '{8'h6D, 8'h3F, 8'h06, Z, Z, Z, Z, Z | 8'h80};

    seg_scan_ctrl #(.SCAN_DIV(4), .BLANK_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .en(en), .digits_in(digits_in), .dp_in(dp_in), .load(load),
        .load_ack(load_ack), .seg_out(seg_out), .digit_sel(digit_sel), .slot(slot), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vec++;
        assert (obs === exp) else begin
            err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic dark(input string tag);
        chk({tag, "_seg"}, seg_out, 8'h00);
        chk({tag, "_sel"}, digit_sel, 8'hFF);
    endtask

    // one slot: 2 dark samples then 4 lit samples; optional load pulse before tick ld_at
    task automatic run_slot(input int s, input logic [7:0] seg_exp, input bit ack, input int ld_at, input logic [31:0] ld_data);
        for (int i = 0; i < 6; i++) begin
            if (i == ld_at) begin
                digits_in = ld_data;
                load = 1'b1;
            end
            tick();
            load = 1'b0;
            chk($sformatf("seg_s%0d_t%0d", s, i), seg_out, i < 2 ? 8'h00 : seg_exp);
            chk($sformatf("sel_s%0d_t%0d", s, i), digit_sel, i < 2 ? 8'hFF : 8'hFF ^ (8'h01 << s));
            chk($sformatf("fdone_s%0d_t%0d", s, i), {7'b0, frame_done}, {7'b0, s == 7 && i == 5});
            chk($sformatf("ack_s%0d_t%0d", s, i), {7'b0, load_ack}, {7'b0, ack && s == 7 && i == 5});
            if (i == 2) chk($sformatf("slot_s%0d", s), {5'b0, slot}, 8'(s));
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; load = 1'b0; digits_in = '0; dp_in = '0;
        tick(); tick();
        dark("rst");
        chk("rst_slot", {5'b0, slot}, 8'h00);
        chk("rst_ack", {7'b0, load_ack}, 8'h00);
        chk("rst_fdone", {7'b0, frame_done}, 8'h00);
        rst = 1'b0;
        digits_in = 32'h76543210; load = 1'b1;
        tick();
        load = 1'b0;
        chk("idle_ack", {7'b0, load_ack}, 8'h01);
        dark("idle");
        tick();
        chk("idle_ack_clr", {7'b0, load_ack}, 8'h00);
        en = 1'b1;
        tick();
        dark("start");
        chk("start_ack", {7'b0, load_ack}, 8'h00);
        for (int s = 0; s < 8; s++) run_slot(s, f1[s], 1'b0, -1, 32'h0);
        for (int s = 0; s < 8; s++) run_slot(s, f1[s], s == 7, s == 3 ? 3 : -1, 32'h00000099);
        for (int s = 0; s < 8; s++) run_slot(s, s < 2 ? 8'h6F : Z, s == 7, s == 7 ? 5 : -1, 32'h87654321);
        for (int s = 0; s < 8; s++) run_slot(s, f4[s], s == 7, s == 1 ? 2 : (s == 3 ? 4 : -1), s == 1 ? 32'h11111111 : 32'h22222222);
        for (int s = 0; s < 5; s++) run_slot(s, 8'h5B, 1'b0, -1, 32'h0);
        tick(); tick();
        dark("s5_blank");
        tick(); tick();
        chk("s5_seg", seg_out, 8'h5B);
        chk("s5_sel", digit_sel, 8'hDF);
        en = 1'b0;
        tick();
        dark("dis");
        chk("dis_slot", {5'b0, slot}, 8'h00);
        chk("dis_fdone", {7'b0, frame_done}, 8'h00);
        tick();
        dark("dis_hold");
        en = 1'b1;
        tick();
        dark("reen");
        for (int s = 0; s < 8; s++) run_slot(s, 8'h5B, 1'b0, -1, 32'h0);
        en = 1'b0;
        tick();
        dark("off");
        digits_in = 32'h00000105; dp_in = 8'h80; load = 1'b1;
        tick();
        load = 1'b0;
        chk("off_ack", {7'b0, load_ack}, 8'h01);
        tick();
        chk("off_ack_clr", {7'b0, load_ack}, 8'h00);
        en = 1'b1;
        tick();
        dark("lz_start");
        for (int s = 0; s < 8; s++) run_slot(s, f7[s], 1'b0, -1, 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed scan controller for an 8-digit common-cathode seven-segment display bank. Holds eight BCD digits and eight decimal-point bits in a shadow register, decodes one digit per slot onto a shared segment bus, and drives an active-low digit-select bus. Inserts a blanking gap between slots to suppress ghosting. Upstream counters and adders load new values through a frame-synchronous load handshake, so a frame never shows a partial update.

## Interface
- SCAN_DIV, 1000: clock cycles each digit is lit (SHOW length); legal 1..65535.
- BLANK_CYCLES, 50: clock cycles of all-off gap before each digit (BLANK length); legal 0..65535.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  scan enable; 0 forces IDLE with the display dark.
- digits_in  in  32  eight BCD nibbles; [3:0] = digit 0 (rightmost), [31:28] = digit 7.
- dp_in  in  8  decimal points; bit i belongs to digit i.
- load  in  1  request to copy digits_in/dp_in into the shadow register; sampled each cycle.
- load_ack  out  1  one-cycle pulse when a pending load is applied.
- seg_out  out  8  registered; [6:0] = segments g..a active-high, [7] = dp active-high.
- digit_sel  out  8  registered, active-low; bit i enables digit i.
- slot  out  3  index of the digit currently in BLANK/SHOW.
- frame_done  out  1  one-cycle pulse at the end of slot 7 SHOW.

## Operation
- States: IDLE, BLANK, SHOW. 16-bit down-counter cnt and 3-bit slot.
- IDLE: digit_sel=8'hFF, seg_out=8'h00, slot=0. If en=1, go to BLANK with cnt=BLANK_CYCLES-1. If BLANK_CYCLES=0, go directly to SHOW.
- BLANK: outputs dark. When cnt=0, go to SHOW with cnt=SCAN_DIV-1.
- SHOW: digit_sel=~(8'h01<<slot), seg_out={dp[slot], dec(shadow[slot])}. When cnt=0:
  - slot increments (7 wraps to 0).
  - Next state is BLANK, or SHOW if BLANK_CYCLES=0.
- dec codes (g..a): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F. Codes 10..15 give 7'h00 (digit dark); the dp bit is still honoured.
- Load handshake:
  - load=1 in any cycle sets pending.
  - pending is applied (shadow<=digits_in/dp_in sampled at that edge, pending cleared, load_ack=1) at the slot-7-to-0 wrap, or on the IDLE-to-active transition.
  - load asserted in the same cycle as the wrap is applied at that wrap.
  - Repeated load while pending: the last sampled data wins, and only one load_ack is issued.
  - In IDLE with en=0, pending is applied immediately, on the next edge.
- en dropped in BLANK/SHOW: next edge enters IDLE, outputs go dark, slot=0, cnt cleared. No frame_done is issued.
- rst mid-frame: same as reset; pending cleared.

## Timing
- Reset values: state=IDLE, seg_out=8'h00, digit_sel=8'hFF, slot=0, load_ack=0, frame_done=0, shadow=0, pending=0.
- With en high at edge k from IDLE, digit 0 appears on outputs at edge k+BLANK_CYCLES+1 and stays for SCAN_DIV cycles.
- Slot period = BLANK_CYCLES+SCAN_DIV. Frame period = 8×(BLANK_CYCLES+SCAN_DIV).
- frame_done and load_ack assert in the same cycle as the first BLANK (or SHOW) cycle of the new frame.
- Never more than one digit_sel bit is low. No cycle drives lit segments while digit_sel=8'hFF transitions to a new slot.

## Configuration
- LZ_BLANK_EN defined: leading-zero suppression.
  - Digit i (i≥1) shows 7'h00 segments if it and every digit above it equal 0. Digit 0 is always shown.
  - dp bits are unaffected.
  - The computation uses the shadow register only.
- LZ_BLANK_EN undefined: every digit is decoded as-is.

## Test plan
- Reset/idle: SCAN_DIV=4, BLANK_CYCLES=2, rst=1, en=0 -> seg_out=00, digit_sel=FF, slot=0, no pulses.
- Scan order:
  - Stimulus: shadow=32'h76543210, en=1.
  - Required response: slots 0..7 each dark 2 cycles then lit 4 cycles; digit_sel FE,FD,...,7F; seg_out 3F,06,5B,4F,66,6D,7D,07; frame_done every 48 cycles.
- Frame-synchronous load:
  - Stimulus: load with digits_in=32'h00000099 mid-slot 3.
  - Required response: slots 3..7 still show the old data; at the wrap load_ack=1 and slot 0 shows 6F.
- Simultaneous load and wrap: load in the wrap cycle -> applied at that wrap; a second load during slot 1 -> applied at the next wrap only.
- Disable mid-SHOW: en=0 during slot 5 -> next edge seg_out=00, digit_sel=FF, slot=0. Re-enable -> restarts at slot 0 BLANK.
- LZ_BLANK_EN: shadow=32'h00000105, dp_in=8'h80 -> digits 7..3 dark except dp on digit 7; digits 2..0 show 06,3F,6D. Without the macro, digits 7..3 show 3F.
